// File: rtl/demux_1_4_stream_pkg.sv
// Shared types and constants for the 1-to-4 stream demultiplexer.
package demux_1_4_stream_pkg;

  localparam int unsigned N_OUT = 4;

  // Output index (2 bits selects one of four outputs)
  typedef logic [1:0] out_idx_t;

  // Routing mode encoding
  localparam logic MODE_SEL = 1'b0;
  localparam logic MODE_RR  = 1'b1;

endpackage

// File: rtl/demux_out_slot.sv
// One-entry output buffer: valid bit plus data register with load/drain/clear.
module demux_out_slot #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             out_ready,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;

  // Drain clears valid, a load wins over a same-cycle drain; data holds on drain
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
    if (load) begin
      valid_d = 1'b1;
      data_d  = load_data;
    end
  end

  // Slot state register, synchronous clear
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;

endmodule

// File: rtl/demux_1_4_stream.sv
// 1-to-4 stream demultiplexer with explicit or round-robin routing.
module demux_1_4_stream
  import demux_1_4_stream_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_sel,
  input  logic             mode,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [WIDTH-1:0] out_data0,
  output logic [WIDTH-1:0] out_data1,
  output logic [WIDTH-1:0] out_data2,
  output logic [WIDTH-1:0] out_data3
);

  out_idx_t           rr_ptr_q, rr_ptr_d;
  out_idx_t           dst_c;
  logic               in_ready_c;
  logic               accept_c;
  logic [N_OUT-1:0]   load_c;
  logic [N_OUT-1:0]   slot_valid;
  logic [WIDTH-1:0]   slot_data [N_OUT];

  // Destination decode, input handshake, slot load strobes and pointer advance
  always_comb begin
    dst_c      = (mode == MODE_RR) ? rr_ptr_q : out_idx_t'(in_sel);
    in_ready_c = !rst && (!slot_valid[dst_c] || out_ready[dst_c]);
    accept_c   = in_valid && in_ready_c;
    load_c     = '0;
    rr_ptr_d   = rr_ptr_q;
    if (accept_c) begin
      load_c[dst_c] = 1'b1;
      if (mode == MODE_RR) begin
        rr_ptr_d = rr_ptr_q + out_idx_t'(1);
      end
    end
  end

  // Round-robin pointer register
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

  for (genvar k = 0; k < int'(N_OUT); k++) begin : g_slot
    demux_out_slot #(.WIDTH(WIDTH)) u_slot (
      .clk       (clk),
      .rst       (rst),
      .load      (load_c[k]),
      .load_data (in_data),
      .out_ready (out_ready[k]),
      .valid     (slot_valid[k]),
      .data      (slot_data[k])
    );
  end

  assign in_ready  = in_ready_c;
  assign out_valid = slot_valid;
  assign out_data0 = slot_data[0];
  assign out_data1 = slot_data[1];
  assign out_data2 = slot_data[2];
  assign out_data3 = slot_data[3];

endmodule

// File: tb/tb_demux_1_4_stream.sv
// Scoreboard bench for demux_1_4_stream.
module tb_demux_1_4_stream;

  localparam int unsigned W = 4;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic [1:0]   in_sel;
  logic         mode;
  logic [3:0]   out_valid;
  logic [3:0]   out_ready;
  logic [W-1:0] out_data0, out_data1, out_data2, out_data3;
  logic [W-1:0] od [4];

  int checks = 0;
  int errors = 0;

  // Scoreboard: one queue of expected words per output
  logic [W-1:0] q [4][$];
  logic [W-1:0] last_m [4];
  logic [1:0]   rr_m;

  demux_1_4_stream #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data0 (out_data0),
    .out_data1 (out_data1),
    .out_data2 (out_data2),
    .out_data3 (out_data3)
  );

  assign od[0] = out_data0;
  assign od[1] = out_data1;
  assign od[2] = out_data2;
  assign od[3] = out_data3;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive, check handshake and drains, update model, check outputs
  task automatic step(input logic r, input logic v, input logic md, input logic [1:0] sel,
                      input logic [W-1:0] d, input logic [3:0] ordy, output logic acc);
    logic [1:0]   dst;
    logic         exp_rdy;
    logic [W-1:0] w;
    logic [3:0]   exp_v;
    @(negedge clk);
    rst = r; in_valid = v; mode = md; in_sel = sel; in_data = d; out_ready = ordy;
    #1;
    dst     = md ? rr_m : sel;
    exp_rdy = !r && (q[dst].size() == 0 || ordy[dst]);
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    acc = v && exp_rdy;
    if (r) begin
      for (int k = 0; k < 4; k++) begin
        q[k].delete();
        last_m[k] = '0;
      end
      rr_m = 2'd0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (q[k].size() != 0 && ordy[k]) begin
          w = q[k].pop_front();
          chk($sformatf("drain_data%0d", k), 32'(od[k]), 32'(w));
        end
      end
      if (acc) begin
        q[dst].push_back(d);
        last_m[dst] = d;
        if (md) rr_m = rr_m + 2'd1;
      end
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) exp_v[k] = (q[k].size() != 0);
    chk("out_valid", 32'(out_valid), 32'(exp_v));
    for (int k = 0; k < 4; k++) chk($sformatf("out_data%0d", k), 32'(od[k]), 32'(last_m[k]));
  endtask

  // Hold a word until accepted, bounded
  task automatic send(input logic md, input logic [1:0] sel, input logic [W-1:0] d,
                      input logic [3:0] ordy);
    logic a;
    int   n;
    a = 1'b0;
    n = 0;
    while (!a && n < 20) begin
      step(1'b0, 1'b1, md, sel, d, ordy, a);
      n++;
    end
    if (!a) chk("send_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    logic         a;
    logic         pend;
    logic [W-1:0] pd;
    logic [1:0]   ps;
    logic         pm;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_sel = '0; mode = 1'b0; out_ready = '0;
    rr_m = 2'd0;
    for (int k = 0; k < 4; k++) last_m[k] = '0;

    // Reset, with in_valid high to confirm no accept
    step(1'b1, 1'b0, 1'b0, 2'd0, 4'h0, 4'hf, a);
    step(1'b1, 1'b1, 1'b0, 2'd1, 4'h7, 4'hf, a);

    // Explicit routing a,b,c,d to outputs 0..3
    send(1'b0, 2'd0, 4'ha, 4'hf);
    send(1'b0, 2'd1, 4'hb, 4'hf);
    send(1'b0, 2'd2, 4'hc, 4'hf);
    send(1'b0, 2'd3, 4'hd, 4'hf);
    step(1'b0, 1'b0, 1'b0, 2'd0, 4'h0, 4'hf, a);

    // Backpressure on output 2
    send(1'b0, 2'd2, 4'h5, 4'b1011);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 2'd2, 4'h6, 4'b1011, a);
    send(1'b0, 2'd2, 4'h6, 4'hf);
    step(1'b0, 1'b0, 1'b0, 2'd0, 4'h0, 4'hf, a);

    // Simultaneous drain and fill on output 1
    send(1'b0, 2'd2, 4'he, 4'b1001);
    send(1'b0, 2'd1, 4'h3, 4'b1001);
    send(1'b0, 2'd1, 4'h4, 4'b1011);
    step(1'b0, 1'b0, 1'b0, 2'd0, 4'h0, 4'hf, a);

    // Round-robin 1..8
    for (int i = 1; i <= 8; i++) send(1'b1, 2'd3, W'(i), 4'hf);
    step(1'b0, 1'b0, 1'b1, 2'd0, 4'h0, 4'hf, a);

    // Round-robin stall on output 1
    for (int i = 9; i <= 13; i++) send(1'b1, 2'd0, W'(i), 4'b1101);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 2'd0, 4'he, 4'b1101, a);
    send(1'b1, 2'd0, 4'he, 4'hf);
    step(1'b0, 1'b0, 1'b0, 2'd0, 4'h0, 4'hf, a);

    // Random traffic, holding a stalled word stable
    pend = 1'b0; pd = '0; ps = '0; pm = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (!pend) begin
        pend = ($urandom_range(0, 3) != 0);
        pd   = W'($urandom);
        ps   = 2'($urandom);
        pm   = 1'($urandom);
      end
      step(1'b0, pend, pm, ps, pd, 4'($urandom), a);
      if (a) pend = 1'b0;
    end
    step(1'b0, 1'b0, 1'b0, 2'd0, 4'h0, 4'hf, a);

    // Fill all slots, then reset mid-operation
    for (int k = 0; k < 4; k++) send(1'b0, 2'(k), W'(k + 1), 4'h0);
    step(1'b1, 1'b1, 1'b1, 2'd2, 4'h8, 4'h0, a);
    send(1'b1, 2'd3, 4'h9, 4'hf);
    step(1'b0, 1'b0, 1'b0, 2'd0, 4'h0, 4'hf, a);
    chk("rr_after_reset_data0", 32'(out_data0), 32'h9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
